// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants for the fetch and decode stages: widths, the NOP
// encoding and the instruction field bit positions.
package fetch_stage_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // Field bit positions shared with decode.
    localparam int COND_HI = 31;
    localparam int COND_LO = 28;
    localparam int OFF_HI  = 23;
    localparam int RN_HI   = 19;
    localparam int RN_LO   = 16;
    localparam int RD_HI   = 15;
    localparam int RD_LO   = 12;
    localparam int IMM_HI  = 11;
    localparam int RM_HI   = 3;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load enable holds contents on stall, synchronous
// squash replaces them with a NOP bubble and takes priority over load.
module if_id_reg #(
    parameter int ADDR_W  = fetch_stage_pkg::ADDR_W,
    parameter int INSTR_W = fetch_stage_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               squash_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  next_pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  next_pc_o,
    output logic               valid_o
);
    import fetch_stage_pkg::*;

    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  next_pc_q;
    logic               valid_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= INSTR_W'(NOP);
            next_pc_q <= '0;
            valid_q   <= 1'b0;
        end else if (squash_i) begin
            instr_q   <= INSTR_W'(NOP);
            next_pc_q <= '0;
            valid_q   <= 1'b0;
        end else if (load_i) begin
            instr_q   <= instr_i;
            next_pc_q <= next_pc_i;
            valid_q   <= 1'b1;
        end
    end

    assign instr_o   = instr_q;
    assign next_pc_o = next_pc_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register with PC+STEP adder, branch redirect,
// IF/ID register, decoded field slices and a saturating fetch counter.
module fetch_stage #(
    parameter int ADDR_W   = fetch_stage_pkg::ADDR_W,
    parameter int INSTR_W  = fetch_stage_pkg::INSTR_W,
    parameter int PC_STEP  = fetch_stage_pkg::PC_STEP,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic               Clk,
    input  logic               Clr,
    input  logic               LE,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ID_instr,
    output logic [ADDR_W-1:0]  ID_next_pc,
    output logic               ID_valid,
    output logic [3:0]         I31_28,
    output logic [3:0]         I19_16,
    output logic [3:0]         I15_12,
    output logic [3:0]         I3_0,
    output logic [23:0]        I23_0,
    output logic [11:0]        I11_0,
    output logic [CNT_W-1:0]   fetch_count
);
    import fetch_stage_pkg::*;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] next_seq;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;

    assign next_seq = pc_q + ADDR_W'(PC_STEP);
    assign accept   = LE && !flush;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (flush) begin
            pc_d = {branch_target[ADDR_W-1:2], 2'b00};
        end else if (LE) begin
            pc_d = next_seq;
        end
        if (accept && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: Clr is asynchronous; the sensitivity list carries its falling edge
    // so clearing does not wait for Clk.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            pc_q  <= ADDR_W'(RESET_PC);
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk       (Clk),
        .rst_n     (Clr),
        .load_i    (LE),
        .squash_i  (flush),
        .instr_i   (imem_data),
        .next_pc_i (next_seq),
        .instr_o   (ID_instr),
        .next_pc_o (ID_next_pc),
        .valid_o   (ID_valid)
    );

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign fetch_count = cnt_q;

    assign I31_28 = ID_instr[COND_HI:COND_LO];
    assign I23_0  = ID_instr[OFF_HI:0];
    assign I19_16 = ID_instr[RN_HI:RN_LO];
    assign I15_12 = ID_instr[RD_HI:RD_LO];
    assign I11_0  = ID_instr[IMM_HI:0];
    assign I3_0   = ID_instr[RM_HI:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall, flush,
// address wrap, zero-word latch and counter saturation (2-bit counter copy).
module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        LE;
    logic        flush;
    logic [7:0]  branch_target;
    logic [7:0]  imem_addr, imem_addr_s;
    logic [31:0] imem_data;
    logic [7:0]  pc, pc_s;
    logic [31:0] ID_instr, ID_instr_s;
    logic [7:0]  ID_next_pc, ID_next_pc_s;
    logic        ID_valid, ID_valid_s;
    logic [3:0]  I31_28, I19_16, I15_12, I3_0;
    logic [3:0]  I31_28_s, I19_16_s, I15_12_s, I3_0_s;
    logic [23:0] I23_0, I23_0_s;
    logic [11:0] I11_0, I11_0_s;
    logic [15:0] fetch_count;
    logic [1:0]  fetch_count_s;

    logic [31:0] mem [0:63];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    assign imem_data = mem[imem_addr[7:2]];

    fetch_stage dut (
        .Clk(Clk), .Clr(Clr), .LE(LE), .flush(flush), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
        .ID_instr(ID_instr), .ID_next_pc(ID_next_pc), .ID_valid(ID_valid),
        .I31_28(I31_28), .I19_16(I19_16), .I15_12(I15_12), .I3_0(I3_0),
        .I23_0(I23_0), .I11_0(I11_0), .fetch_count(fetch_count)
    );

    // Same stimulus, 2-bit counter so saturation is reached in a few fetches.
    fetch_stage #(.CNT_W(2)) dut_sat (
        .Clk(Clk), .Clr(Clr), .LE(LE), .flush(flush), .branch_target(branch_target),
        .imem_addr(imem_addr_s), .imem_data(imem_data), .pc(pc_s),
        .ID_instr(ID_instr_s), .ID_next_pc(ID_next_pc_s), .ID_valid(ID_valid_s),
        .I31_28(I31_28_s), .I19_16(I19_16_s), .I15_12(I15_12_s), .I3_0(I3_0_s),
        .I23_0(I23_0_s), .I11_0(I11_0_s), .fetch_count(fetch_count_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1234_5678 ^ (i * 32'h0101_0101);
        mem[0] = 32'h0000_0000;

        Clr = 1'b0; LE = 1'b0; flush = 1'b0; branch_target = 8'h00;
        #1;
        check("por_pc", 32'(pc), 32'h00);
        check("por_valid", 32'(ID_valid), 32'h0);
        @(negedge Clk);
        Clr = 1'b1;

        // Reach pc=0x24 with a fetch in flight, then clear between edges.
        flush = 1'b1; branch_target = 8'h20;
        cyc();
        flush = 1'b0; LE = 1'b1;
        cyc();
        check("pre_clr_pc", 32'(pc), 32'h24);
        check("pre_clr_cnt", 32'(fetch_count), 32'h1);
        LE = 1'b0;
        #2 Clr = 1'b0;
        #1;
        check("clr_pc", 32'(pc), 32'h00);
        check("clr_instr", ID_instr, 32'h0);
        check("clr_valid", 32'(ID_valid), 32'h0);
        check("clr_cnt", 32'(fetch_count), 32'h0);
        check("clr_fields", {I31_28, I23_0, I3_0}, 32'h0);
        @(negedge Clk);
        Clr = 1'b1;

        // Sequential fetch from RESET_PC; word at 0x00 is all-zero but valid.
        LE = 1'b1;
        cyc();
        check("seq1_pc", 32'(pc), 32'h04);
        check("seq1_instr_zero", ID_instr, 32'h0);
        check("seq1_valid", 32'(ID_valid), 32'h1);
        check("seq1_next_pc", 32'(ID_next_pc), 32'h04);
        cyc();
        cyc();
        check("seq3_pc", 32'(pc), 32'h0C);
        check("seq3_imem_addr", 32'(imem_addr), 32'h0C);
        check("seq3_instr", ID_instr, 32'h1036_547A);
        check("seq3_next_pc", 32'(ID_next_pc), 32'h0C);
        check("seq3_I31_28", 32'(I31_28), 32'h1);
        check("seq3_I23_0", 32'(I23_0), 32'h36_547A);
        check("seq3_I19_16", 32'(I19_16), 32'h6);
        check("seq3_I15_12", 32'(I15_12), 32'h5);
        check("seq3_I11_0", 32'(I11_0), 32'h47A);
        check("seq3_I3_0", 32'(I3_0), 32'hA);
        check("seq3_cnt", 32'(fetch_count), 32'd3);
        check("seq3_cnt_sat", 32'(fetch_count_s), 32'd3);

        // Stall two edges, then resume.
        LE = 1'b0;
        cyc();
        cyc();
        check("stall_pc", 32'(pc), 32'h0C);
        check("stall_instr", ID_instr, 32'h1036_547A);
        check("stall_valid", 32'(ID_valid), 32'h1);
        check("stall_cnt", 32'(fetch_count), 32'd3);
        LE = 1'b1;
        cyc();
        check("resume_instr", ID_instr, 32'h1137_557B);
        check("resume_next_pc", 32'(ID_next_pc), 32'h10);
        check("resume_cnt", 32'(fetch_count), 32'd4);
        check("sat_hold", 32'(fetch_count_s), 32'd3);

        // Flush wins over stall; target low bits dropped.
        LE = 1'b0; flush = 1'b1; branch_target = 8'h43;
        cyc();
        check("flush_pc", 32'(pc), 32'h40);
        check("flush_instr", ID_instr, 32'h0);
        check("flush_valid", 32'(ID_valid), 32'h0);
        check("flush_next_pc", 32'(ID_next_pc), 32'h00);
        check("flush_cnt", 32'(fetch_count), 32'd4);
        flush = 1'b0; LE = 1'b1;
        cyc();
        check("tgt_instr", ID_instr, 32'h0224_4668);
        check("tgt_next_pc", 32'(ID_next_pc), 32'h44);
        check("tgt_cnt", 32'(fetch_count), 32'd5);

        // Flush with LE=1 still squashes; then wrap from 0xFC.
        flush = 1'b1; branch_target = 8'hFF;
        cyc();
        check("flush_le_pc", 32'(pc), 32'hFC);
        check("flush_le_valid", 32'(ID_valid), 32'h0);
        check("flush_le_cnt", 32'(fetch_count), 32'd5);
        flush = 1'b0;
        cyc();
        check("wrap_pc", 32'(pc), 32'h00);
        check("wrap_next_pc", 32'(ID_next_pc), 32'h00);
        check("wrap_instr", ID_instr, 32'h2D0B_6947);
        check("wrap_cnt", 32'(fetch_count), 32'd6);
        check("sat_final", 32'(fetch_count_s), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
